// File: rtl/logic_op_pkg.sv
// Shared types and the opcode evaluator for logic_op_core.
// Shift/rotate opcodes 8..11 are compiled in only when LOGIC_OP_EXT_OPS_EN is defined.
package logic_op_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_NAND  = 4'd3,
    OP_NOR   = 4'd4,
    OP_XNOR  = 4'd5,
    OP_NOTA  = 4'd6,
    OP_PASSA = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ROL   = 4'd10,
    OP_ROR   = 4'd11
  } op_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    op_e        op;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP_WAIT
  } state_e;

  // Returns {legal, result}; unlisted opcodes are reported illegal with a zero result.
  function automatic logic [4:0] op_eval(input logic [3:0] a, input logic [3:0] b, input op_e op);
    logic       legal;
    logic [3:0] res;
`ifdef LOGIC_OP_EXT_OPS_EN
    logic [7:0] dbl;
    dbl = {a, a};
`endif
    legal = 1'b1;
    res   = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XNOR:  res = ~(a ^ b);
      OP_NOTA:  res = ~a;
      OP_PASSA: res = a;
`ifdef LOGIC_OP_EXT_OPS_EN
      OP_SHL:   res = a << b[1:0];
      OP_SHR:   res = a >> b[1:0];
      OP_ROL: begin
        dbl = dbl << b[1:0];
        res = dbl[7:4];
      end
      OP_ROR: begin
        dbl = dbl >> b[1:0];
        res = dbl[3:0];
      end
`endif
      default:  legal = 1'b0;
    endcase
    return {legal, res};
  endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// Synchronous command FIFO with occupancy count; async active-high reset.
module logic_op_fifo
  import logic_op_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/logic_op_core.sv
// Logic-op execution stage: buffered commands, one result pulse per command, GAP spacing.
// Build option: LOGIC_OP_EXT_OPS_EN enables shift/rotate opcodes in logic_op_pkg::op_eval.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP        = 0,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  input  logic [3:0]    in_op,
  output logic [3:0]    data,
  output logic          data_en,
  output logic          err,
  output logic [LW-1:0] fifo_level
);

  localparam bit         HAS_GAP  = (GAP != 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_e     state;
  state_e     state_nx;
  logic [3:0] gap_cnt;
  entry_t     wdata;
  entry_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       issue;
  logic       ev_legal;
  logic [3:0] ev_res;
  logic       remaining;

  assign wdata    = '{a: in_a, b: in_b, op: op_e'(in_op)};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign issue    = (state == ST_ISSUE);

  logic_op_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(wdata),
    .pop  (issue),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  assign {ev_legal, ev_res} = op_eval(head.a, head.b, head.op);

  // Level still counts the entry being popped; a same-cycle push keeps the pipe busy.
  assign remaining = (fifo_level > LW'(1)) || push;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ev_legal && HAS_GAP) state_nx = ST_GAP_WAIT;
        else if (remaining)      state_nx = ST_ISSUE;
        else                     state_nx = ST_IDLE;
      end
      ST_GAP_WAIT: begin
        if (gap_cnt == '0) state_nx = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      data    <= '0;
      data_en <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue)                                   gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
      data_en <= issue && ev_legal;
      err     <= issue && !ev_legal;
      if (issue && ev_legal) data <= ev_res;
    end
  end

endmodule

// File: tb/tb_logic_op_core.sv
// Scoreboard bench for logic_op_core: directed vectors, decoupled stimulus and monitor.
module tb_logic_op_core;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 3;
`ifdef LOGIC_OP_EXT_OPS_EN
  localparam logic [3:0] ILL_OP = 4'd12;
`else
  localparam logic [3:0] ILL_OP = 4'd9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic [3:0] data;
  logic       data_en;
  logic       err;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  logic_op_core #(
    .FIFO_DEPTH(DEPTH),
    .GAP       (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .data      (data),
    .data_en   (data_en),
    .err       (err),
    .fifo_level(fifo_level)
  );

  typedef struct {
    bit         is_err;
    logic [3:0] val;
    int         exp_cyc;
    int         exp_delta;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_pulse = -1000;
  int         pulses = 0;
  int         snap;
  logic [3:0] model_data = '0;
  int         prev_level = 0;
  bit         prev_push = 1'b0;
  bit         lvl_ok = 1'b0;
  bit         saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+#1; inputs held until the accepting edge has passed.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      input bit is_err, input logic [3:0] val, input int dcyc, input int delta);
    int   budget;
    exp_t e;
    budget   = 200;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    while (!in_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (!in_ready) begin
      check("accept_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    e.is_err    = is_err;
    e.val       = val;
    e.exp_cyc   = (dcyc >= 0) ? cyc + 1 + dcyc : -1;
    e.exp_delta = delta;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: result pulses against the scoreboard, plus an occupancy model.
  always @(negedge clk) begin
    if (rst) begin
      lvl_ok = 1'b0;
    end else begin
      if (data_en || err) begin
        pulses++;
        check("pulse_exclusive", 32'(data_en & err), 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("data_en_kind", 32'(data_en), 32'(!mon_e.is_err));
          check("err_kind", 32'(err), 32'(mon_e.is_err));
          if (mon_e.is_err) begin
            check("data_hold_on_err", 32'(data), 32'(model_data));
          end else begin
            check("data", 32'(data), 32'(mon_e.val));
            model_data = mon_e.val;
          end
          if (mon_e.exp_cyc >= 0)   check("latency", cyc, mon_e.exp_cyc);
          if (mon_e.exp_delta >= 0) check("spacing", cyc - last_pulse, mon_e.exp_delta);
        end
        last_pulse = cyc;
      end
      if (lvl_ok)
        check("fifo_level", 32'(fifo_level), 32'(prev_level + int'(prev_push) - int'(data_en || err)));
      check("in_ready_vs_level", 32'(in_ready), 32'(fifo_level != 3'(DEPTH)));
      check("level_max", 32'(fifo_level <= 3'(DEPTH)), 1);
      if (fifo_level == 3'(DEPTH)) saw_full = 1'b1;
      prev_level = int'(fifo_level);
      prev_push  = in_valid && in_ready;
      lvl_ok     = 1'b1;
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] res;
  } vec_t;

  vec_t fill_vec[8] = '{
    '{4'hC, 4'hA, 4'd0, 4'h8},
    '{4'hC, 4'hA, 4'd1, 4'hE},
    '{4'hC, 4'hA, 4'd3, 4'h7},
    '{4'hC, 4'hA, 4'd4, 4'h1},
    '{4'hC, 4'hA, 4'd5, 4'h9},
    '{4'h3, 4'h0, 4'd6, 4'hC},
    '{4'h5, 4'h0, 4'd7, 4'h5},
    '{4'hF, 4'h0, 4'd2, 4'hF}
  };

  initial begin
    int budget;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_data", 32'(data), 0);
    check("rst_data_en", 32'(data_en), 0);
    check("rst_err", 32'(err), 0);
    check("rst_level", 32'(fifo_level), 0);
    rst = 1'b0;
    idle(2);

    // Single XOR: result 2 cycles after accept
    send(4'hC, 4'hA, 4'd2, 1'b0, 4'h6, 2, -1);
    drain();
    idle(8);

    // Illegal opcode: err pulse, data held, next legal op in the very next cycle
    send(4'h5, 4'h5, ILL_OP, 1'b1, 4'h0, 2, -1);
    send(4'h6, 4'h3, 4'd0, 1'b0, 4'h2, -1, 1);
    drain();
    idle(8);

`ifdef LOGIC_OP_EXT_OPS_EN
    send(4'b1001, 4'd1, 4'd10, 1'b0, 4'b0011, 2, -1);
    send(4'b1001, 4'd1, 4'd9,  1'b0, 4'b0100, -1, GAP + 1);
    send(4'b1001, 4'd1, 4'd8,  1'b0, 4'b0010, -1, GAP + 1);
    send(4'b1001, 4'd1, 4'd11, 1'b0, 4'b1100, -1, GAP + 1);
    drain();
    idle(8);
`endif

    // Continuous valid: fills the FIFO, back-pressure, fixed spacing
    for (int i = 0; i < 8; i++)
      send(fill_vec[i].a, fill_vec[i].b, fill_vec[i].op, 1'b0, fill_vec[i].res,
           (i == 0) ? 2 : -1, (i == 0) ? -1 : GAP + 1);
    drain();
    idle(8);
    check("saw_full", 32'(saw_full), 1);

    // Reset with three entries still queued
    for (int i = 0; i < 4; i++)
      send(fill_vec[i].a, fill_vec[i].b, fill_vec[i].op, 1'b0, fill_vec[i].res,
           (i == 0) ? 2 : -1, (i == 0) ? -1 : GAP + 1);
    budget = 50;
    while (sb.size() > 3 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("pre_rst_queue", sb.size(), 3);
    check("pre_rst_level", 32'(fifo_level), 3);
    #1;
    rst = 1'b1;
    sb.delete();
    model_data = '0;
    last_pulse = -1000;
    #1;
    check("midrst_data_en", 32'(data_en), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_level", 32'(fifo_level), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_data", 32'(data), 0);
    snap = pulses;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(15);
    check("no_pulse_after_rst", pulses, snap);
    check("post_rst_level", 32'(fifo_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
